axi_lite_mem_slave: RTL
=======================

Name: axi_lite_mem_slave

Overview:
- AXI4-Lite slave responder backed by a word-addressed register memory.
- Acts as the synthesizable counterpart to the M00_AXI test-pattern master in the verification_ip example designs; it replaces the slave VIP in block designs.
- Accepts writes with byte strobes and serves single-beat reads.
- Returns SLVERR for addresses beyond the memory.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
- C_S_AXI_ADDR_WIDTH, 12, byte address width.
- C_MEM_DEPTH, 64, number of data words; power of 2; C_MEM_DEPTH*(DATA_WIDTH/8) <= 2**ADDR_WIDTH.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S00_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S00_AXI_AWPROT  in  3  ignored.
- S00_AXI_AWVALID  in  1  write address valid.
- S00_AXI_AWREADY  out  1  write address ready.
- S00_AXI_WDATA  in  DATA_WIDTH  write data.
- S00_AXI_WSTRB  in  DATA_WIDTH/8  byte-lane enables.
- S00_AXI_WVALID  in  1  write data valid.
- S00_AXI_WREADY  out  1  write data ready.
- S00_AXI_BRESP  out  2  write response.
- S00_AXI_BVALID  out  1  write response valid.
- S00_AXI_BREADY  in  1  write response ready.
- S00_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S00_AXI_ARPROT  in  3  ignored.
- S00_AXI_ARVALID  in  1  read address valid.
- S00_AXI_ARREADY  out  1  read address ready.
- S00_AXI_RDATA  out  DATA_WIDTH  read data.
- S00_AXI_RRESP  out  2  read response.
- S00_AXI_RVALID  out  1  read data valid.
- S00_AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset:
  - While ARESETN=0, all outputs are 0 and the holding registers are empty.
  - READY outputs are registered; they rise on the first ACLK edge after reset release.
  - Memory contents are not reset; they are retained across reset.
- Address decode:
  - ADDR_LSB = log2(DATA_WIDTH/8); address bits below ADDR_LSB are ignored.
  - Word index = ADDR >> ADDR_LSB.
  - Index >= C_MEM_DEPTH is out of range.
- Write channel states:
  - IDLE → HOLD_AW, HOLD_W or BOTH → RESP → IDLE.
  - The AW and W holding registers fill independently.
  - AWREADY is high only when the AW register is empty and BVALID=0. WREADY follows the same rule for the W register.
  - AW and W handshakes may occur in the same cycle or in either order, with any gap between them.
- Write commit:
  - On the edge after both registers are full, commit the write and assert BVALID.
  - Write latency: AW and W handshaking together in cycle N gives BVALID in cycle N+1.
  - Byte lane i is written iff WSTRB[i]=1.
  - In range: BRESP=OKAY (2'b00). Out of range: BRESP=SLVERR (2'b10) and memory is untouched.
- Write response:
  - BVALID and BRESP hold until BREADY=1.
  - On the B handshake, both holding registers clear; AWREADY and WREADY return high on the next cycle.
  - At most one write is outstanding.
- Read channel states: IDLE (ARREADY=1) → RESP (RVALID=1, ARREADY=0) → IDLE.
  - An AR handshake in cycle N gives RVALID, RDATA and RRESP in cycle N+1.
  - RDATA and RRESP hold stable until RREADY=1.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - ARREADY returns high on the cycle after the R handshake, so maximum throughput is one read per 2 cycles.
- Read/write collision:
  - A read sampled on the same edge as a write commit to the same word returns the old data.
  - A read whose AR handshake comes after the commit edge returns the new data.
- Channel independence: the read and write channels do not stall each other.
- Reset mid-transaction:
  - In-flight AW, W, B and R state is discarded immediately (asynchronous).
  - An uncommitted write never reaches memory.
  - A write already committed stays in memory.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp_t (2 bits), RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Function addr_lsb(data_width).
  - Write FSM enum wr_state_t and read FSM enum rd_state_t.
- Sub-module axi_lite_mem_ram holds the memory array. It has:
  - a synchronous byte-enabled write port;
  - a synchronous read port with read-before-write semantics.
  - It has no reset.

Test Plan:
- Write 0xDEADBEEF to 0x010 with AW and W in the same cycle, WSTRB=4'hF, then read 0x010 → BVALID 1 cycle after the handshake with BRESP=00; RDATA=0xDEADBEEF, RRESP=00.
- Send W (0x11223344) 3 cycles before AW (0x020), then a second write with AW before W → both give BRESP=00 and AWREADY/WREADY stay low until B completes; readback matches.
- Write 0xAABBCCDD to 0x030, then write 0x000000EE with WSTRB=4'b0001 → read 0x030 returns 0xAABBCCEE.
- Write and read address 0x100 (index 64 ≥ depth) → BRESP=10 and RRESP=10 with RDATA=0; a prior read of 0x0FC is unchanged after the write.
- Hold BREADY/RREADY low for 5 cycles → BVALID/RVALID and BRESP/RDATA/RRESP stay stable; no new AW/AR is accepted.
- Write 0x12345678 to 0x040, then pulse ARESETN low mid-write after the AW handshake only (W not yet sent) → all outputs 0 immediately; after reset, 0x040 reads 0x12345678; READY signals high 1 cycle after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes, write/read FSM states, address helper.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // A write whose AW and W arrive together goes straight from IDLE to RESP.
  typedef enum logic [1:0] {WR_IDLE, WR_HOLD_AW, WR_HOLD_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_mem_ram.sv
// Word memory: byte-enabled synchronous write, registered read returning pre-write data.
// One-cycle read latency, no reset, no flow control (caller gates the enables).
module axi_lite_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  input  logic [DATA_WIDTH/8-1:0]    i_wstrb,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]      o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (i_wstrb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave over a word memory; B one cycle after last of AW/W, R one cycle after AR.
// Single outstanding write and read; READY drops while a response waits for B/RREADY.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_MEM_DEPTH        = 64
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_AWADDR,
  input  logic [2:0]                      S00_AXI_AWPROT,
  input  logic                            S00_AXI_AWVALID,
  output logic                            S00_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S00_AXI_WSTRB,
  input  logic                            S00_AXI_WVALID,
  output logic                            S00_AXI_WREADY,
  output logic [1:0]                      S00_AXI_BRESP,
  output logic                            S00_AXI_BVALID,
  input  logic                            S00_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_ARADDR,
  input  logic [2:0]                      S00_AXI_ARPROT,
  input  logic                            S00_AXI_ARVALID,
  output logic                            S00_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_RDATA,
  output logic [1:0]                      S00_AXI_RRESP,
  output logic                            S00_AXI_RVALID,
  input  logic                            S00_AXI_RREADY
);

  localparam int ADDR_LSB = addr_lsb(C_S_AXI_DATA_WIDTH);
  localparam int MEM_AW   = $clog2(C_MEM_DEPTH);
  localparam int NB       = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] DEPTH_A = C_S_AXI_ADDR_WIDTH'(C_MEM_DEPTH);

  wr_state_t                       r_wr_state;
  logic                            r_awready, r_wready, r_bvalid;
  resp_t                           r_bresp;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [NB-1:0]                   r_wstrb;

  logic                            w_aw_hs, w_w_hs, w_have_aw, w_have_w, w_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_wr_addr, w_wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_wr_data;
  logic [NB-1:0]                   w_wr_strb;
  logic                            w_wr_oor;

  // A channel's beat counts as held if it is in its register or handshaking right now,
  // so the commit lands on the same edge as the later of the two handshakes.
  assign w_aw_hs   = S00_AXI_AWVALID & r_awready;
  assign w_w_hs    = S00_AXI_WVALID & r_wready;
  assign w_have_aw = (r_wr_state == WR_HOLD_AW) | w_aw_hs;
  assign w_have_w  = (r_wr_state == WR_HOLD_W) | w_w_hs;
  assign w_commit  = w_have_aw & w_have_w;
  assign w_wr_addr = w_aw_hs ? S00_AXI_AWADDR : r_awaddr;
  assign w_wr_data = w_w_hs ? S00_AXI_WDATA : r_wdata;
  assign w_wr_strb = w_w_hs ? S00_AXI_WSTRB : r_wstrb;
  assign w_wr_idx  = w_wr_addr >> ADDR_LSB;
  assign w_wr_oor  = (w_wr_idx >= DEPTH_A);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= S00_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S00_AXI_WDATA;
        r_wstrb <= S00_AXI_WSTRB;
      end
      case (r_wr_state)
        WR_RESP: begin
          if (S00_AXI_BREADY) begin
            r_wr_state <= WR_IDLE;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
          end
        end
        default: begin
          if (w_commit) begin
            r_wr_state <= WR_RESP;
            r_bvalid   <= 1'b1;
            r_bresp    <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
          end else begin
            r_wr_state <= w_have_aw ? WR_HOLD_AW : (w_have_w ? WR_HOLD_W : WR_IDLE);
            r_awready  <= ~w_have_aw;
            r_wready   <= ~w_have_w;
          end
        end
      endcase
    end
  end

  rd_state_t                       r_rd_state;
  logic                            r_arready, r_rvalid, r_rd_oor;
  resp_t                           r_rresp;
  logic                            w_ar_hs, w_rd_oor;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_ram_rdata;

  assign w_ar_hs  = S00_AXI_ARVALID & r_arready;
  assign w_rd_idx = S00_AXI_ARADDR >> ADDR_LSB;
  assign w_rd_oor = (w_rd_idx >= DEPTH_A);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rd_oor   <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= RD_RESP;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rresp    <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
            r_rd_oor   <= w_rd_oor;
          end else begin
            r_arready  <= 1'b1;
          end
        end
        default: begin
          if (S00_AXI_RREADY) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_arready  <= 1'b1;
          end
        end
      endcase
    end
  end

  axi_lite_mem_ram #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .DEPTH      (C_MEM_DEPTH)
  ) u_ram (
    .clk     (ACLK),
    .i_we    (w_commit & ~w_wr_oor),
    .i_waddr (w_wr_idx[MEM_AW-1:0]),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .i_re    (w_ar_hs),
    .i_raddr (w_rd_idx[MEM_AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // The RAM output register is not reset, so mask it outside a valid in-range response.
  assign S00_AXI_RDATA   = (r_rvalid & ~r_rd_oor) ? w_ram_rdata : '0;
  assign S00_AXI_AWREADY = r_awready;
  assign S00_AXI_WREADY  = r_wready;
  assign S00_AXI_BVALID  = r_bvalid;
  assign S00_AXI_BRESP   = r_bresp;
  assign S00_AXI_ARREADY = r_arready;
  assign S00_AXI_RVALID  = r_rvalid;
  assign S00_AXI_RRESP   = r_rresp;

  logic w_unused;
  assign w_unused = ^{S00_AXI_AWPROT, S00_AXI_ARPROT};

endmodule
